screen_erase_engine: RTL
========================

# screen_erase_engine

Block-fill engine that sits directly upstream of the character buffer write port: it forwards ordinary single-character writes from the command handler and, on request, sweeps a region of the 64×16 buffer writing a fill character, one cell per clock. It implements the VT52 erase operations: erase to end of line, erase to end of screen, clear screen and erase line. Its output is the `{row, col}` address / char / write-enable triple consumed by the char generator's buffer.

## Interface
Parameters:
- `COL_BITS`, default 6, column address width (64 columns).
- `ROW_BITS`, default 4, row address width (16 rows).
- `FILL_CHAR`, default 8'h20, byte written to erased cells.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clr`  in  1  synchronous active-high reset.
- `cmd_valid`  in  1  erase request.
- `cmd_ready`  out  1  engine can accept a request or write.
- `cmd_op`  in  2  00 erase to end of line, 01 erase to end of screen, 10 clear screen, 11 erase whole line.
- `cmd_row`  in  ROW_BITS  cursor row for the request.
- `cmd_col`  in  COL_BITS  cursor column for the request.
- `in_char`  in  8  pass-through character.
- `in_addr`  in  ROW_BITS+COL_BITS  pass-through address `{row, col}`.
- `in_wen`  in  1  pass-through write strobe; honoured only when `cmd_ready`=1.
- `out_char`  out  8  buffer write data.
- `out_addr`  out  ROW_BITS+COL_BITS  buffer write address.
- `out_wen`  out  1  buffer write strobe.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the last fill write.

## Operation
- States: IDLE, SWEEP, FINISH.
- IDLE:
  - `cmd_ready`=1.
  - `in_wen`=1 registers `in_addr`/`in_char` to the outputs with `out_wen`=1.
  - `cmd_valid`=1 latches the start and end addresses and moves to SWEEP.
- Start and end addresses (N = 2^(ROW_BITS+COL_BITS) - 1 = 1023):
  - op00: start `{row,col}`, end `{row,63}`.
  - op01: start `{row,col}`, end N.
  - op10: start 0, end N.
  - op11: start `{row,0}`, end `{row,63}`.
- `cmd_valid` and `in_wen` in the same IDLE cycle:
  - Both are accepted.
  - The pass-through write is emitted first; the sweep begins on the following cycle.
- SWEEP:
  - `cmd_ready`=0, `busy`=1.
  - Each cycle emits `out_wen`=1, `out_addr`=counter, `out_char`=FILL_CHAR.
  - The counter increments by 1.
  - After the cycle that emits the end address, the state moves to FINISH.
  - Counter never wraps: the end address is always ≥ start, and the sweep stops at end even when end = N.
- While busy:
  - `in_wen` and `cmd_valid` are ignored; no data is lost because the upstream waits on `cmd_ready`.
- FINISH:
  - `done`=1 for one cycle, `out_wen`=0, `busy`=0, `cmd_ready`=1.
  - The next cycle is IDLE; a request presented during FINISH is accepted.
- Writes emitted per op: op00 = 64-col; op01 = 1024-(row·64+col); op10 = 1024; op11 = 64.

## Timing
- Reset values: `out_wen`=0, `out_addr`=0, `out_char`=0, `busy`=0, `done`=0, `cmd_ready`=1, state IDLE.
  - Exception: with `CLEAR_ON_RESET_EN`, see Configuration.
- `clr` asserted mid-sweep aborts on that edge. No further fill writes are emitted and no `done` pulse is produced.
- Pass-through latency: 1 cycle from `in_wen` sample to `out_wen`.
- Sweep latency:
  - Request accepted at edge E.
  - First fill write is on the outputs after E+1, or after E+2 if a pass-through write was accepted at E.
  - Fills are back-to-back, one per cycle, with no bubbles.
  - `done` follows the cycle after the last fill.
- `out_wen` is deasserted in every cycle with no write. Every output is registered.

## Configuration
- `CLEAR_ON_RESET_EN` defined:
  - The cycle after `clr` deasserts, the engine runs an op10 sweep (1024 fills of FILL_CHAR, addresses 0..1023) and ends with `done`.
  - During reset, `busy`=0 and `cmd_ready`=0.
  - `cmd_ready` rises only in FINISH.
- Not defined:
  - The engine leaves reset in IDLE with `cmd_ready`=1.
  - No writes are emitted until requested.

## Test plan
- Pass-through: `in_wen`=1, `in_addr`=10'h041, `in_char`=8'h41 → next cycle `out_wen`=1, `out_addr`=10'h041, `out_char`=8'h41; following cycle `out_wen`=0.
- op00 at row 3, col 60 → exactly 4 writes to 0x0FC..0x0FF with char 0x20, then `done` pulse; `cmd_ready` low throughout.
- op01 at row 15, col 62 → 2 writes (0x3FE, 0x3FF), no write to 0x000, `done`; op10 → 1024 consecutive writes 0x000..0x3FF.
- Same-cycle `in_wen` (addr 0x005, char 0x58) and op11 at row 2 → write 0x005/0x58 first, then 64 fills 0x080..0x0BF.
- `clr` asserted after the 10th fill of op10 → `out_wen`=0 on the next cycle, `done` never pulses, `cmd_ready`=1.
- `CLEAR_ON_RESET_EN` defined, release `clr` → 1024 fills starting the next cycle, `cmd_ready`=0 until FINISH, then a pass-through write is accepted.

Source files
------------

// File: rtl/screen_erase_engine.sv
// rtl/screen_erase_engine.sv - character buffer write mux with VT52 erase sweeps (optional CLEAR_ON_RESET_EN)
module screen_erase_engine #(
    parameter int         COL_BITS  = 6,
    parameter int         ROW_BITS  = 4,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [ROW_BITS-1:0]          cmd_row,
    input  logic [COL_BITS-1:0]          cmd_col,
    input  logic [7:0]                   in_char,
    input  logic [ROW_BITS+COL_BITS-1:0] in_addr,
    input  logic                         in_wen,
    output logic [7:0]                   out_char,
    output logic [ROW_BITS+COL_BITS-1:0] out_addr,
    output logic                         out_wen,
    output logic                         busy,
    output logic                         done
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  end_q, end_d;
    logic                  gap_q, gap_d;
    logic                  last_q, last_d;
    logic [7:0]            out_char_q, out_char_d;
    logic [ADDR_BITS-1:0]  out_addr_q, out_addr_d;
    logic                  out_wen_q, out_wen_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic [ADDR_BITS-1:0]  start_addr;
    logic [ADDR_BITS-1:0]  stop_addr;

    // Decode the request into an inclusive sweep range; end is never below start.
    always_comb begin
        start_addr = {cmd_row, cmd_col};
        stop_addr  = {cmd_row, {COL_BITS{1'b1}}};
        case (cmd_op)
            2'b00: begin
                start_addr = {cmd_row, cmd_col};
                stop_addr  = {cmd_row, {COL_BITS{1'b1}}};
            end
            2'b01: begin
                start_addr = {cmd_row, cmd_col};
                stop_addr  = {ADDR_BITS{1'b1}};
            end
            2'b10: begin
                start_addr = {ADDR_BITS{1'b0}};
                stop_addr  = {ADDR_BITS{1'b1}};
            end
            default: begin
                start_addr = {cmd_row, {COL_BITS{1'b0}}};
                stop_addr  = {cmd_row, {COL_BITS{1'b1}}};
            end
        endcase
    end

    // Next state and next output values; status outputs follow the next state
    // so that every output is a flop aligned with the write it describes.
    // gap_q inserts one idle cycle after a same-cycle pass-through write;
    // last_q holds SWEEP for the cycle in which the final fill is on the bus.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        end_d      = end_q;
        gap_d      = gap_q;
        last_d     = last_q;
        out_char_d = out_char_q;
        out_addr_d = out_addr_q;
        out_wen_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                state_d = ST_IDLE;
                if (in_wen) begin
                    out_wen_d  = 1'b1;
                    out_addr_d = in_addr;
                    out_char_d = in_char;
                end
                if (cmd_valid) begin
                    state_d = ST_SWEEP;
                    cnt_d   = start_addr;
                    end_d   = stop_addr;
                    gap_d   = in_wen;
                    last_d  = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (last_q) begin
                    state_d = ST_FINISH;
                    last_d  = 1'b0;
                end else if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    out_wen_d  = 1'b1;
                    out_addr_d = cnt_q;
                    out_char_d = FILL_CHAR;
                    cnt_d      = cnt_q + ADDR_ONE;
                    if (cnt_q == end_q) begin
                        last_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d == ST_SWEEP);
        done_d      = (state_d == ST_FINISH);
        cmd_ready_d = (state_d != ST_SWEEP);
    end

    // State and output registers with synchronous reset; the clear-on-reset
    // build parks in a full-screen sweep that starts as soon as clr drops.
    always_ff @(posedge clk) begin
        if (clr) begin
`ifdef CLEAR_ON_RESET_EN
            state_q     <= ST_SWEEP;
            cnt_q       <= {ADDR_BITS{1'b0}};
            end_q       <= {ADDR_BITS{1'b1}};
            cmd_ready_q <= 1'b0;
`else
            state_q     <= ST_IDLE;
            cnt_q       <= {ADDR_BITS{1'b0}};
            end_q       <= {ADDR_BITS{1'b0}};
            cmd_ready_q <= 1'b1;
`endif
            gap_q       <= 1'b0;
            last_q      <= 1'b0;
            out_char_q  <= 8'h00;
            out_addr_q  <= {ADDR_BITS{1'b0}};
            out_wen_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            end_q       <= end_d;
            cmd_ready_q <= cmd_ready_d;
            gap_q       <= gap_d;
            last_q      <= last_d;
            out_char_q  <= out_char_d;
            out_addr_q  <= out_addr_d;
            out_wen_q   <= out_wen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign out_char  = out_char_q;
    assign out_addr  = out_addr_q;
    assign out_wen   = out_wen_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
